btn_debouncer: RTL
==================

// Module: btn_debouncer
// PURPOSE
//   Conditions raw push-button inputs before they reach the ALU toplevel's i_btn
//   load strobes (btn[0] load A, btn[1] load B, btn[2] load op).
//   - Per button: 2-FF synchroniser, then counter-based debounce FSM.
//   - Outputs a clean level per button, plus a one-cycle press pulse.
//   - The toplevel consumes o_btn_pulse so one physical press loads one operand exactly once.
// PARAMETERS
//   NB_BTN          3          number of buttons
//   NB_CNT          20         debounce counter width
//   DEBOUNCE_CYCLES 1_000_000  cycles input must be stable (10 ms @ 100 MHz); legal 2..2**NB_CNT-1
// PORTS
//   clock        in   1       system clock, all logic on rising edge
//   i_reset      in   1       asynchronous, active-low reset
//   i_btn_raw    in   NB_BTN  raw, asynchronous, bouncing buttons (1 = pressed)
//   o_btn        out  NB_BTN  debounced level per button
//   o_btn_pulse  out  NB_BTN  1-cycle strobe on each accepted press
// BEHAVIOUR
//   - Reset (i_reset=0, async assert):
//     - All sync FFs, counters, o_btn and o_btn_pulse clear to 0.
//     - Every FSM goes to IDLE.
//     - i_btn_raw is ignored while reset is asserted.
//   - Reset release is synchronous to clock.
//   - Synchroniser: sync = ff2 <- ff1 <- i_btn_raw. Two cycles of latency.
//   - Per-button FSM. cnt clears on every state change. N = DEBOUNCE_CYCLES.
//     - IDLE (level 0):
//       - sync=1 -> WAIT_PRESS.
//     - WAIT_PRESS:
//       - sync=0 -> IDLE (glitch rejected, no output change).
//       - cnt==N-1 -> PRESSED; assert o_btn_pulse for one cycle.
//       - otherwise cnt++.
//     - PRESSED (level 1):
//       - sync=0 -> WAIT_RELEASE.
//     - WAIT_RELEASE (level 1):
//       - sync=1 -> PRESSED (release bounce rejected, no new pulse).
//       - cnt==N-1 -> IDLE.
//       - otherwise cnt++.
//   - Outputs are registered.
//     - o_btn = 1 in PRESSED and WAIT_RELEASE.
//     - o_btn_pulse = 1 only in the cycle after the WAIT_PRESS->PRESSED edge.
//   - Latency: a raw level held stable from sampling edge E is reflected on o_btn,
//     and o_btn_pulse rises, after edge E+N+2 (2 sync + 1 FSM entry + N-1 count + 1 transition).
//   - Pulse is never longer than 1 cycle. At most one pulse per accepted press,
//     however long the button is held.
//   - Buttons are fully independent. Simultaneous presses give pulses in the same
//     cycle if the raw edges land in the same cycle.
//   - Counter never wraps: it is compared against N-1 and cleared on exit.
//   - Async reset mid-count clears everything. A subsequent press restarts a full N-cycle count.
// STRUCTURE
//   - Shared package (alu_io_pkg):
//     - 2-bit state encoding: IDLE=0, WAIT_PRESS=1, PRESSED=2, WAIT_RELEASE=3.
//     - Default DEBOUNCE_CYCLES / NB_CNT constants.
//   - Sub-module btn_debounce_cell: handles 1 button (sync FFs + FSM + counter + output regs).
//   - btn_debouncer instantiates NB_BTN cells via generate and concatenates the outputs.
//   - Elaboration check: DEBOUNCE_CYCLES < 2**NB_CNT and >= 2.
// TESTING  (bench overrides DEBOUNCE_CYCLES=4, NB_CNT=3; 10 ns clock)
//   1. i_reset=0 with i_btn_raw=3'b111 held 10 cycles -> o_btn=0, o_btn_pulse=0 throughout.
//   2. btn[0] raw high 20 cycles from edge E -> o_btn_pulse[0]=1 for exactly the cycle
//      after edge E+6. o_btn[0]=1 from then until 6 edges after the release is sampled.
//   3. btn[1] raw high 3 cycles, then low -> o_btn[1]=0 and o_btn_pulse[1]=0 always.
//   4. btn[2] pressed and accepted, then raw low 2 cycles, then high again ->
//      o_btn[2] stays 1, no second pulse.
//   5. i_btn_raw 3'b000->3'b101 on one edge, held -> o_btn_pulse=3'b101 in a single
//      cycle, then 3'b000. o_btn=3'b101.
//   6. btn[0] high, i_reset pulsed low 1 cycle mid-WAIT_PRESS, btn held ->
//      outputs clear immediately. Pulse comes 7 edges after reset release, not earlier.

Source files
------------

// File: rtl/alu_io_pkg.sv
// Shared definitions for the ALU I/O conditioning blocks: debounce FSM
// state encoding and default debounce timing.
package alu_io_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      PRESSED      = 2'd2,
      WAIT_RELEASE = 2'd3
   } dbnc_state_e;

   localparam int DEF_NB_CNT          = 20;
   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/btn_debounce_cell.sv
// One push-button channel: 2-FF synchroniser, counter-based debounce FSM and
// registered level / press-pulse outputs.
module btn_debounce_cell
   import alu_io_pkg::*;
#(
   parameter int NB_CNT          = DEF_NB_CNT,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clock,
   input  logic i_reset,
   input  logic i_btn_raw,
   output logic o_btn,
   output logic o_btn_pulse
);

   localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);
   localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

   logic              sync1_q;
   logic              sync2_q;
   dbnc_state_e       state_q, state_d;
   logic [NB_CNT-1:0] cnt_q, cnt_d;
   logic              btn_q, btn_d;
   logic              pulse_q, pulse_d;

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         btn_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= i_btn_raw;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         btn_q   <= btn_d;
         pulse_q <= pulse_d;
      end
   end

   // The counter is cleared on every state change, so it starts from zero
   // in both waiting states and can never run past CNT_LAST.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (sync2_q) begin
               state_d = WAIT_PRESS;
               cnt_d   = '0;
            end
         end
         WAIT_PRESS: begin
            if (!sync2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         PRESSED: begin
            if (!sync2_q) begin
               state_d = WAIT_RELEASE;
               cnt_d   = '0;
            end
         end
         WAIT_RELEASE: begin
            if (sync2_q) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      btn_d   = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
      pulse_d = (state_q == WAIT_PRESS) && (state_d == PRESSED);
   end

   assign o_btn       = btn_q;
   assign o_btn_pulse = pulse_q;

endmodule

// File: rtl/btn_debouncer.sv
// Debounces NB_BTN raw push-buttons into clean levels and one-cycle press
// strobes used as the ALU operand/op load signals.
module btn_debouncer
   import alu_io_pkg::*;
#(
   parameter int NB_BTN          = 3,
   parameter int NB_CNT          = DEF_NB_CNT,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic [NB_BTN-1:0] i_btn_raw,
   output logic [NB_BTN-1:0] o_btn,
   output logic [NB_BTN-1:0] o_btn_pulse
);

   if ((DEBOUNCE_CYCLES < 2) || (64'(DEBOUNCE_CYCLES) >= (64'd1 << NB_CNT))) begin : g_bad_cfg
      $error("btn_debouncer: DEBOUNCE_CYCLES must be in 2..2**NB_CNT-1");
   end

   for (genvar gi = 0; gi < NB_BTN; gi++) begin : g_cell
      btn_debounce_cell #(
         .NB_CNT          (NB_CNT),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_cell (
         .clock       (clock),
         .i_reset     (i_reset),
         .i_btn_raw   (i_btn_raw[gi]),
         .o_btn       (o_btn[gi]),
         .o_btn_pulse (o_btn_pulse[gi])
      );
   end

endmodule
